// File: rtl/round_clip_pipe_pkg.sv
// Shared DSP constants: rounding-mode selectors and the saturation counter width.
package round_clip_pipe_pkg;
   localparam int RND_TRUNC     = 0;
   localparam int RND_HALF_UP   = 1;
   localparam int RND_HALF_EVEN = 2;
   localparam int CLIP_CNT_W    = 16;
endpackage

// File: rtl/round_half_even.sv
// Combinational rounding of a signed sample by DROP LSBs; result is one bit wider
// than the kept field so a round-up at the positive limit cannot wrap.
module round_half_even
   import round_clip_pipe_pkg::*;
#(
   parameter int W_IN = 18,
   parameter int DROP = 4,
   parameter int MODE = RND_HALF_EVEN
) (
   input  logic signed [W_IN-1:0]    din,
   output logic signed [W_IN-DROP:0] dout
);
   localparam int WR = W_IN - DROP + 1;

   logic signed [WR-1:0] trunc;
   logic [DROP:0]        frac_z;
   logic                 half_bit;
   logic                 sticky;
   logic                 rnd_up;

   always_comb begin
      trunc    = {din[W_IN-1], din[W_IN-1:DROP]};
      // Appending a zero keeps the sticky slice legal even when DROP == 1.
      frac_z   = {din[DROP-1:0], 1'b0};
      half_bit = frac_z[DROP];
      sticky   = |frac_z[DROP-1:0];
      case (MODE)
         RND_TRUNC:   rnd_up = 1'b0;
         RND_HALF_UP: rnd_up = half_bit;
         default:     rnd_up = half_bit & (sticky | trunc[0]);
      endcase
      dout = trunc + {{(WR-1){1'b0}}, rnd_up};
   end
endmodule

// File: rtl/round_clip_pipe.sv
// Two-stage round (S1) and saturate (S2) pipeline with AXI-stream style handshakes
// and a saturating count of clipped samples that leave the block.
module round_clip_pipe
   import round_clip_pipe_pkg::*;
#(
   parameter int WIDTH_IN  = 18,
   parameter int WIDTH_OUT = 12,
   parameter int CLIP_BITS = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [WIDTH_IN-1:0]   in_tdata,
   input  logic                         in_tvalid,
   input  logic                         in_tlast,
   output logic                         in_tready,
   output logic signed [WIDTH_OUT-1:0]  out_tdata,
   output logic                         out_tvalid,
   output logic                         out_tlast,
   input  logic                         out_tready,
   input  logic                         clear_count,
   output logic [CLIP_CNT_W-1:0]        clip_count
);
   // DROP must be >= 1 for the rounding stage to be meaningful.
   localparam int DROP   = WIDTH_IN - WIDTH_OUT - CLIP_BITS;
   localparam int WR     = WIDTH_IN - DROP + 1;
   localparam int STAGES = 2;

   localparam logic signed [WR-1:0] MAXV = {{(WR-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
   localparam logic signed [WR-1:0] MINV = {{(WR-WIDTH_OUT+1){1'b1}}, {(WIDTH_OUT-1){1'b0}}};
   localparam logic [WIDTH_OUT-1:0] MAX_OUT = {1'b0, {(WIDTH_OUT-1){1'b1}}};
   localparam logic [WIDTH_OUT-1:0] MIN_OUT = {1'b1, {(WIDTH_OUT-1){1'b0}}};
   localparam logic [CLIP_CNT_W-1:0] CNT_MAX = {CLIP_CNT_W{1'b1}};

   logic [STAGES:1]          vld_pipe;
   logic signed [WR-1:0]     rnd;
   logic signed [WR-1:0]     s1_data;
   logic                     s1_last;
   logic [WIDTH_OUT-1:0]     s2_data;
   logic                     s2_last;
   logic                     s2_clip;
   logic [CLIP_CNT_W-1:0]    clip_cnt;
   logic                     s1_rdy, s2_rdy, out_xfer;
   logic                     sat_hi, sat_lo;
   logic [WIDTH_OUT-1:0]     sat_val;

   round_half_even #(.W_IN(WIDTH_IN), .DROP(DROP), .MODE(RND_HALF_EVEN)) u_rnd (
      .din  (in_tdata),
      .dout (rnd)
   );

   // A stage may load when it is empty or its content moves on this cycle.
   assign s2_rdy    = !vld_pipe[2] | out_tready;
   assign s1_rdy    = !vld_pipe[1] | s2_rdy;
   assign in_tready = s1_rdy;
   assign out_xfer  = vld_pipe[2] & out_tready;

   always_comb begin
      sat_hi  = s1_data > MAXV;
      sat_lo  = s1_data < MINV;
      sat_val = s1_data[WIDTH_OUT-1:0];
      if (sat_hi)      sat_val = MAX_OUT;
      else if (sat_lo) sat_val = MIN_OUT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_data  <= '0;
         s1_last  <= 1'b0;
         s2_data  <= '0;
         s2_last  <= 1'b0;
         s2_clip  <= 1'b0;
      end else begin
         if (s1_rdy) begin
            vld_pipe[1] <= in_tvalid;
            if (in_tvalid) begin
               s1_data <= rnd;
               s1_last <= in_tlast;
            end
         end
         if (s2_rdy) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               s2_data <= sat_val;
               s2_last <= s1_last;
               s2_clip <= sat_hi | sat_lo;
            end
         end
      end
   end

   // A clear landing on a counted transfer still records that transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_cnt <= '0;
      end else if (out_xfer && s2_clip) begin
         if (clear_count)           clip_cnt <= CLIP_CNT_W'(1);
         else if (clip_cnt != CNT_MAX) clip_cnt <= clip_cnt + CLIP_CNT_W'(1);
      end else if (clear_count) begin
         clip_cnt <= '0;
      end
   end

   assign out_tdata  = s2_data;
   assign out_tvalid = vld_pipe[2];
   assign out_tlast  = s2_last;
   assign clip_count = clip_cnt;
endmodule

// File: tb/tb_round_clip_pipe.sv
// Directed bench for round_clip_pipe: rounding, saturation, backpressure, tlast,
// mid-stream reset and clip counter limits.
module tb_round_clip_pipe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [17:0] in_tdata;
   logic        in_tvalid, in_tlast, in_tready;
   logic [11:0] out_tdata;
   logic        out_tvalid, out_tlast, out_tready;
   logic        clear_count;
   logic [15:0] clip_count;
   int          errors = 0;
   int          checks = 0;

   round_clip_pipe #(.WIDTH_IN(18), .WIDTH_OUT(12), .CLIP_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready),
      .clear_count(clear_count), .clip_count(clip_count)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%0h exp=0", out_tvalid); end
      checks++; if (out_tdata !== 12'h000) begin errors++; $display("FAIL reset_tdata got=%0h exp=0", out_tdata); end
      checks++; if (out_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%0h exp=0", out_tlast); end
      checks++; if (clip_count !== 16'h0000) begin errors++; $display("FAIL reset_count got=%0h exp=0", clip_count); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL reset_tready got=%0h exp=1", in_tready); end
   endtask

   // Back-to-back inputs: each output appears exactly two cycles after its input.
   task automatic test_rounding();
      logic [17:0] vin [3];
      logic [11:0] vexp [3];
      vin  = '{18'h00008, 18'h00018, 18'h00028};
      vexp = '{12'h000, 12'h002, 12'h002};
      out_tready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         in_tvalid = (c < 3);
         in_tdata  = (c < 3) ? vin[c] : 18'h0;
         if (c < 2) begin
            checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL round_lat c=%0d got_valid=%0h exp=0", c, out_tvalid); end
         end else begin
            checks++; if (out_tvalid !== 1'b1 || out_tdata !== vexp[c-2]) begin
               errors++; $display("FAIL round_out c=%0d got=%0h/%0h exp=1/%0h", c, out_tvalid, out_tdata, vexp[c-2]);
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      logic [17:0] vin [4];
      logic [11:0] vexp [4];
      vin  = '{18'h1FFFF, 18'h20000, 18'h07FF0, 18'h07FF8};
      vexp = '{12'h7FF, 12'h800, 12'h7FF, 12'h7FF};
      clear_count = 1'b1;
      @(posedge clk); #1 clear_count = 1'b0;
      checks++; if (clip_count !== 16'h0) begin errors++; $display("FAIL sat_clear got=%0h exp=0", clip_count); end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         in_tvalid = (c < 4);
         in_tdata  = (c < 4) ? vin[c] : 18'h0;
         if (c >= 2) begin
            checks++; if (out_tvalid !== 1'b1 || out_tdata !== vexp[c-2]) begin
               errors++; $display("FAIL sat_out c=%0d got=%0h/%0h exp=1/%0h", c, out_tvalid, out_tdata, vexp[c-2]);
            end
         end
      end
      repeat (2) @(posedge clk); #1;
      checks++; if (clip_count !== 16'd3) begin errors++; $display("FAIL sat_count got=%0d exp=3", clip_count); end
   endtask

   task automatic test_backpressure();
      int nin = 0, nout = 0, occ;
      logic hold = 1'b0;
      logic [11:0] held = '0;
      for (int cyc = 0; cyc < 400 && nout < 20; cyc++) begin
         @(posedge clk); #1;
         out_tready = 1'($urandom_range(0, 1));
         in_tvalid  = (nin < 20);
         in_tdata   = 18'((nin - 10) * 16);
         in_tlast   = 1'b0;
         if (hold) begin
            checks++; if (out_tvalid !== 1'b1 || out_tdata !== held) begin
               errors++; $display("FAIL bp_stable got=%0h/%0h exp=1/%0h", out_tvalid, out_tdata, held);
            end
         end
         @(negedge clk);
         occ = nin - nout;
         checks++; if (in_tready !== !(occ == 2 && !out_tready)) begin
            errors++; $display("FAIL bp_tready got=%0h exp=%0h occ=%0d", in_tready, !(occ == 2 && !out_tready), occ);
         end
         if (out_tvalid && out_tready) begin
            checks++; if (out_tdata !== 12'(nout - 10)) begin
               errors++; $display("FAIL bp_data idx=%0d got=%0h exp=%0h", nout, out_tdata, 12'(nout - 10));
            end
            nout++;
         end
         if (in_tvalid && in_tready) nin++;
         hold = out_tvalid & !out_tready;
         held = out_tdata;
      end
      checks++; if (nout != 20) begin errors++; $display("FAIL bp_count got=%0d exp=20", nout); end
      @(posedge clk); #1;
      in_tvalid  = 1'b0;
      out_tready = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_tlast();
      int nin = 0, nout = 0, stall = 0;
      for (int cyc = 0; cyc < 50 && nout < 4; cyc++) begin
         @(posedge clk); #1;
         in_tvalid  = (nin < 4);
         in_tdata   = 18'((nin + 1) * 16);
         in_tlast   = (nin == 3);
         out_tready = !(out_tvalid && nout == 3 && stall < 3);
         if (!out_tready) stall++;
         @(negedge clk);
         if (out_tvalid) begin
            checks++; if (out_tlast !== (nout == 3)) begin
               errors++; $display("FAIL tlast idx=%0d got=%0h exp=%0h", nout, out_tlast, (nout == 3));
            end
         end
         if (out_tvalid && out_tready) begin
            checks++; if (out_tdata !== 12'(nout + 1)) begin
               errors++; $display("FAIL tlast_data idx=%0d got=%0h exp=%0h", nout, out_tdata, 12'(nout + 1));
            end
            nout++;
         end
         if (in_tvalid && in_tready) nin++;
      end
      checks++; if (nout != 4 || stall != 3) begin errors++; $display("FAIL tlast_done got=%0d/%0d exp=4/3", nout, stall); end
      @(posedge clk); #1;
      in_tvalid = 1'b0;
      in_tlast  = 1'b0;
      out_tready = 1'b1;
   endtask

   task automatic test_reset_midstream();
      out_tready = 1'b0;
      @(posedge clk); #1;
      in_tvalid = 1'b1;
      in_tdata  = 18'h1FFFF;
      repeat (2) @(posedge clk);
      #1 in_tvalid = 1'b0;
      checks++; if (in_tready !== 1'b0 || out_tvalid !== 1'b1) begin
         errors++; $display("FAIL mid_full got=%0h/%0h exp=0/1", in_tready, out_tvalid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL mid_tvalid got=%0h exp=0", out_tvalid); end
      checks++; if (clip_count !== 16'h0) begin errors++; $display("FAIL mid_count got=%0h exp=0", clip_count); end
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL mid_tready got=%0h exp=1", in_tready); end
      out_tready = 1'b1;
      in_tvalid  = 1'b1;
      in_tdata   = 18'h00100;
      @(posedge clk); #1 in_tvalid = 1'b0;
      checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL mid_stale got=%0h exp=0", out_tvalid); end
      @(posedge clk); #1;
      checks++; if (out_tvalid !== 1'b1 || out_tdata !== 12'h010) begin
         errors++; $display("FAIL mid_first got=%0h/%0h exp=1/010", out_tvalid, out_tdata);
      end
      @(posedge clk); #1;
      checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL mid_dup got=%0h exp=0", out_tvalid); end
   endtask

   task automatic test_counter_edges();
      out_tready = 1'b1;
      in_tdata   = 18'h1FFFF;
      in_tvalid  = 1'b1;
      repeat (65535) @(posedge clk);
      #1 in_tvalid = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (clip_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_full got=%0h exp=ffff", clip_count); end
      in_tvalid = 1'b1;
      @(posedge clk); #1 in_tvalid = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (clip_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got=%0h exp=ffff", clip_count); end
      out_tready = 1'b0;
      in_tdata   = 18'h20000;
      in_tvalid  = 1'b1;
      @(posedge clk); #1 in_tvalid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_tvalid !== 1'b1 || out_tdata !== 12'h800) begin
         errors++; $display("FAIL cnt_stage got=%0h/%0h exp=1/800", out_tvalid, out_tdata);
      end
      out_tready  = 1'b1;
      clear_count = 1'b1;
      @(posedge clk); #1 clear_count = 1'b0;
      checks++; if (clip_count !== 16'd1) begin errors++; $display("FAIL cnt_clear_xfer got=%0h exp=1", clip_count); end
   endtask

   initial begin
      in_tdata = '0; in_tvalid = 1'b0; in_tlast = 1'b0;
      out_tready = 1'b1; clear_count = 1'b0;
      test_reset();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_tlast();
      test_reset_midstream();
      test_counter_edges();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
